// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bundle for pc_fetch_unit: redirect controls, program ROM port and decoder handshake.
// PC_BREAKPOINT_EN adds the breakpoint arm/address/hit signals.
interface pc_fetch_unit_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 18
);
  logic               PC_LD;
  logic [1:0]         PC_MUX_SEL;
  logic [ADDR_W-1:0]  FROM_IMMED;
  logic [ADDR_W-1:0]  FROM_STACK;
  logic [INSTR_W-1:0] PROG_IR;
  logic [ADDR_W-1:0]  PROG_ADDR;
  logic [INSTR_W-1:0] IR_OUT;
  logic [ADDR_W-1:0]  PC_COUNT;
  logic               IR_VALID;
  logic               IR_ACCEPT;
`ifdef PC_BREAKPOINT_EN
  logic               BRK_ARM;
  logic [ADDR_W-1:0]  BRK_ADDR;
  logic               BRK_HIT;

  modport master (
    input  PC_LD, PC_MUX_SEL, FROM_IMMED, FROM_STACK, PROG_IR, IR_ACCEPT, BRK_ARM, BRK_ADDR,
    output PROG_ADDR, IR_OUT, PC_COUNT, IR_VALID, BRK_HIT
  );
  modport slave (
    output PC_LD, PC_MUX_SEL, FROM_IMMED, FROM_STACK, PROG_IR, IR_ACCEPT, BRK_ARM, BRK_ADDR,
    input  PROG_ADDR, IR_OUT, PC_COUNT, IR_VALID, BRK_HIT
  );
`else
  modport master (
    input  PC_LD, PC_MUX_SEL, FROM_IMMED, FROM_STACK, PROG_IR, IR_ACCEPT,
    output PROG_ADDR, IR_OUT, PC_COUNT, IR_VALID
  );
  modport slave (
    output PC_LD, PC_MUX_SEL, FROM_IMMED, FROM_STACK, PROG_IR, IR_ACCEPT,
    input  PROG_ADDR, IR_OUT, PC_COUNT, IR_VALID
  );
`endif
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer in front of the synchronous program ROM: 1-cycle ROM,
// 1-entry skid, valid/accept output. Optional breakpoint halt enabled by PC_BREAKPOINT_EN.
module pc_fetch_unit #(
  parameter int                ADDR_W     = 10,
  parameter int                INSTR_W    = 18,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] INTR_VEC   = '1
) (
  input  logic             CLK,
  input  logic             RST_N,
  pc_fetch_unit_if.master  fetch
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t             state_reg;
  logic [ADDR_W-1:0]  prog_addr_reg;
  logic               inflight_reg;
  logic [ADDR_W-1:0]  inflight_pc_reg;
  logic               out_valid_reg;
  logic [INSTR_W-1:0] out_ir_reg;
  logic [ADDR_W-1:0]  out_pc_reg;
  logic               skid_full_reg;
  logic [INSTR_W-1:0] skid_ir_reg;
  logic [ADDR_W-1:0]  skid_pc_reg;
`ifdef PC_BREAKPOINT_EN
  logic               brk_hit_reg;
`endif

  logic               out_free;
  logic               issue_ok;
  logic               brk_stop;
  logic               do_issue;
  logic [ADDR_W-1:0]  redirect_target;

  always_comb begin
    out_free = !out_valid_reg || fetch.IR_ACCEPT;
    // A word already in flight behind a stalled output must land in the skid; don't start another.
    issue_ok = !skid_full_reg && !(inflight_reg && out_valid_reg && !fetch.IR_ACCEPT);
    redirect_target = RESET_ADDR;
    case (fetch.PC_MUX_SEL)
      2'd0:    redirect_target = fetch.FROM_IMMED;
      2'd1:    redirect_target = fetch.FROM_STACK;
      2'd2:    redirect_target = INTR_VEC;
      default: redirect_target = RESET_ADDR;
    endcase
  end

`ifdef PC_BREAKPOINT_EN
  assign brk_stop = (state_reg == ST_RUN) && fetch.BRK_ARM && (prog_addr_reg == fetch.BRK_ADDR);
`else
  assign brk_stop = 1'b0;
`endif

  assign do_issue = issue_ok && (state_reg == ST_RUN) && !brk_stop && !fetch.PC_LD;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg       <= ST_RUN;
      prog_addr_reg   <= RESET_ADDR;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      out_valid_reg   <= 1'b0;
      out_ir_reg      <= '0;
      out_pc_reg      <= '0;
      skid_full_reg   <= 1'b0;
      skid_ir_reg     <= '0;
      skid_pc_reg     <= '0;
`ifdef PC_BREAKPOINT_EN
      brk_hit_reg     <= 1'b0;
`endif
    end else if (fetch.PC_LD) begin
      // Redirect discards everything in the pipe; the target is issued next cycle.
      state_reg     <= ST_RUN;
      prog_addr_reg <= redirect_target;
      inflight_reg  <= 1'b0;
      skid_full_reg <= 1'b0;
      out_valid_reg <= 1'b0;
`ifdef PC_BREAKPOINT_EN
      brk_hit_reg   <= 1'b0;
`endif
    end else begin
      inflight_reg <= do_issue;
      if (do_issue) begin
        inflight_pc_reg <= prog_addr_reg;
        prog_addr_reg   <= prog_addr_reg + ADDR_W'(1);
      end

      // Skid holds the older word, so it refills the output before fresh ROM data.
      if (out_free) begin
        if (skid_full_reg) begin
          out_valid_reg <= 1'b1;
          out_ir_reg    <= skid_ir_reg;
          out_pc_reg    <= skid_pc_reg;
          skid_full_reg <= 1'b0;
        end else if (inflight_reg) begin
          out_valid_reg <= 1'b1;
          out_ir_reg    <= fetch.PROG_IR;
          out_pc_reg    <= inflight_pc_reg;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end else if (inflight_reg) begin
        skid_full_reg <= 1'b1;
        skid_ir_reg   <= fetch.PROG_IR;
        skid_pc_reg   <= inflight_pc_reg;
      end

`ifdef PC_BREAKPOINT_EN
      case (state_reg)
        ST_RUN: begin
          if (brk_stop) begin
            state_reg   <= ST_HALT;
            brk_hit_reg <= 1'b1;
          end
        end
        ST_HALT: begin
          if (!fetch.BRK_ARM) begin
            state_reg   <= ST_RUN;
            brk_hit_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_RUN;
      endcase
`endif
    end
  end

  assign fetch.PROG_ADDR = prog_addr_reg;
  assign fetch.IR_OUT    = out_ir_reg;
  assign fetch.PC_COUNT  = out_pc_reg;
  assign fetch.IR_VALID  = out_valid_reg;
`ifdef PC_BREAKPOINT_EN
  assign fetch.BRK_HIT   = brk_hit_reg;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed fetch/stall/redirect/reset cases, then random accept and
// redirect traffic checked against an in-order instruction stream model.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_fetch_unit_if #(.ADDR_W(10), .INSTR_W(18)) fetch ();

  pc_fetch_unit #(.ADDR_W(10), .INSTR_W(18)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .fetch (fetch)
  );

  logic [17:0] rom [1024];
  always @(posedge clk) fetch.PROG_IR <= rom[fetch.PROG_ADDR];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int redirect_pc(input logic [1:0] sel, input logic [9:0] imm, input logic [9:0] stk);
    case (sel)
      2'd0:    return int'(imm);
      2'd1:    return int'(stk);
      2'd2:    return 'h3FF;
      default: return 0;
    endcase
  endfunction

  // Stream model: accepted words must be consecutive addresses from the last reset/redirect.
  int          exp_pc = 0;
  int          n_acc = 0;
  int          gap = 0;
  bit          halted = 1'b0;
  bit          verbose = 1'b1;
  bit          hold_q = 1'b0;
  logic [17:0] hold_ir;
  logic [9:0]  hold_pc;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc = 0;
      hold_q = 1'b0;
      gap = 0;
    end else begin
      if (hold_q) begin
        check("hold_valid", 32'(fetch.IR_VALID), 1);
        check("hold_ir", 32'(fetch.IR_OUT), 32'(hold_ir));
        check("hold_pc", 32'(fetch.PC_COUNT), 32'(hold_pc));
      end
      if (fetch.IR_VALID && fetch.IR_ACCEPT) begin
        if (verbose) $display("txn pc=%03h ir=%05h", fetch.PC_COUNT, fetch.IR_OUT);
        check("stream_pc", 32'(fetch.PC_COUNT), 32'(exp_pc));
        check("stream_ir", 32'(fetch.IR_OUT), 32'(rom[exp_pc]));
        exp_pc = (exp_pc + 1) % 1024;
        n_acc++;
      end
      hold_q  = fetch.IR_VALID && !fetch.IR_ACCEPT && !fetch.PC_LD;
      hold_ir = fetch.IR_OUT;
      hold_pc = fetch.PC_COUNT;
      if (fetch.PC_LD) begin
        exp_pc = redirect_pc(fetch.PC_MUX_SEL, fetch.FROM_IMMED, fetch.FROM_STACK);
        gap = 0;
      end else if (fetch.IR_VALID || halted) begin
        gap = 0;
      end else begin
        gap++;
        check("bubble_run_ok", 32'(gap <= 6), 1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect_and_check(input logic [1:0] sel, input logic [9:0] imm,
                                    input logic [9:0] stk, input logic [9:0] tgt);
    fetch.PC_LD = 1'b1;
    fetch.PC_MUX_SEL = sel;
    fetch.FROM_IMMED = imm;
    fetch.FROM_STACK = stk;
    step(1);
    fetch.PC_LD = 1'b0;
    check("redir_addr", 32'(fetch.PROG_ADDR), 32'(tgt));
    check("redir_valid_n1", 32'(fetch.IR_VALID), 0);
    step(1);
    check("redir_valid_n2", 32'(fetch.IR_VALID), 0);
    step(1);
    check("redir_valid_n3", 32'(fetch.IR_VALID), 1);
    check("redir_pc", 32'(fetch.PC_COUNT), 32'(tgt));
    check("redir_ir", 32'(fetch.IR_OUT), 32'(tgt) + 'h100);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 18'(i + 'h100);
    rst_n = 1'b0;
    fetch.PC_LD = 1'b0;
    fetch.PC_MUX_SEL = 2'd0;
    fetch.FROM_IMMED = '0;
    fetch.FROM_STACK = '0;
    fetch.IR_ACCEPT = 1'b1;
`ifdef PC_BREAKPOINT_EN
    fetch.BRK_ARM = 1'b0;
    fetch.BRK_ADDR = '0;
`endif
    step(2);
    rst_n = 1'b1;

    // Reset state and straight-line fetch.
    check("rst_addr", 32'(fetch.PROG_ADDR), 0);
    check("rst_valid", 32'(fetch.IR_VALID), 0);
    check("rst_ir", 32'(fetch.IR_OUT), 0);
    check("rst_pc", 32'(fetch.PC_COUNT), 0);
    step(1);
    check("c1_addr", 32'(fetch.PROG_ADDR), 1);
    check("c1_valid", 32'(fetch.IR_VALID), 0);
    step(1);
    for (int k = 0; k < 4; k++) begin
      check("seq_valid", 32'(fetch.IR_VALID), 1);
      check("seq_pc", 32'(fetch.PC_COUNT), 32'(k));
      check("seq_ir", 32'(fetch.IR_OUT), 32'(k + 'h100));
      check("seq_addr", 32'(fetch.PROG_ADDR), 32'(k + 2));
      step(1);
    end

    // Decoder stall at PC_COUNT=4.
    check("stall_pc0", 32'(fetch.PC_COUNT), 4);
    fetch.IR_ACCEPT = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("stall_ir", 32'(fetch.IR_OUT), 'h104);
      check("stall_addr", 32'(fetch.PROG_ADDR), 6);
    end
    fetch.IR_ACCEPT = 1'b1;
    step(1);
    check("release_pc", 32'(fetch.PC_COUNT), 5);
    step(4);
    check("pre_redir_valid", 32'(fetch.IR_VALID), 1);

    redirect_and_check(2'd0, 10'h050, 10'h000, 10'h050);
    redirect_and_check(2'd2, 10'h000, 10'h000, 10'h3FF);
    step(1);
    check("wrap_pc", 32'(fetch.PC_COUNT), 0);
    check("wrap_ir", 32'(fetch.IR_OUT), 'h100);
    redirect_and_check(2'd1, 10'h000, 10'h123, 10'h123);

    // Reset while output is held and the skid is full.
    fetch.IR_ACCEPT = 1'b0;
    step(2);
    check("skid_valid", 32'(fetch.IR_VALID), 1);
    check("skid_pc", 32'(fetch.PC_COUNT), 'h123);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    fetch.IR_ACCEPT = 1'b1;
    check("mrst_valid", 32'(fetch.IR_VALID), 0);
    check("mrst_addr", 32'(fetch.PROG_ADDR), 0);
    check("mrst_pc", 32'(fetch.PC_COUNT), 0);
    step(2);
    check("mrst_first_pc", 32'(fetch.PC_COUNT), 0);
    check("mrst_first_ir", 32'(fetch.IR_OUT), 'h100);
    step(1);
    check("mrst_second_pc", 32'(fetch.PC_COUNT), 1);

`ifdef PC_BREAKPOINT_EN
    rst_n = 1'b0;
    fetch.BRK_ARM = 1'b1;
    fetch.BRK_ADDR = 10'h008;
    step(1);
    rst_n = 1'b1;
    check("brk_rst_hit", 32'(fetch.BRK_HIT), 0);
    halted = 1'b1;
    step(14);
    check("brk_hit", 32'(fetch.BRK_HIT), 1);
    check("brk_valid", 32'(fetch.IR_VALID), 0);
    check("brk_addr", 32'(fetch.PROG_ADDR), 8);
    check("brk_last_pc", 32'(exp_pc), 8);
    fetch.BRK_ARM = 1'b0;
    step(3);
    check("brk_resume_pc", 32'(fetch.PC_COUNT), 8);
    check("brk_resume_valid", 32'(fetch.IR_VALID), 1);
    check("brk_clear", 32'(fetch.BRK_HIT), 0);
    halted = 1'b0;
`endif

    // Random phase with fresh ROM contents loaded under reset.
    verbose = 1'b0;
    rst_n = 1'b0;
    step(1);
    for (int i = 0; i < 1024; i++) rom[i] = 18'($urandom);
    step(1);
    rst_n = 1'b1;
    begin
      int acc_start;
      acc_start = n_acc;
      for (int c = 0; c < 3000; c++) begin
        fetch.IR_ACCEPT = ($urandom_range(0, 3) != 0);
        fetch.PC_LD = ($urandom_range(0, 15) == 0);
        fetch.PC_MUX_SEL = 2'($urandom_range(0, 3));
        fetch.FROM_IMMED = 10'($urandom);
        fetch.FROM_STACK = 10'($urandom);
        rst_n = ($urandom_range(0, 199) != 0);
        step(1);
      end
      fetch.PC_LD = 1'b0;
      rst_n = 1'b1;
      check("rand_throughput_ok", 32'((n_acc - acc_start) > 500), 1);
    end
    step(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
